// File: rtl/wtm4_share_arbiter.sv
// wtm4_share_arbiter: round-robin sharing of one combinational 4x4 Wallace-tree
// multiplier among NREQ requesters. Operands are registered ahead of the core
// and the product is registered after it. A single response channel returns
// each product tagged with the index of the requester that supplied it.
// Optional build macro: WTM_ARB_BACK2BACK_EN. When it is defined, arbitration
// also runs in the response handshake cycle, giving one product per 2 cycles.

// Combinational 4x4 unsigned Wallace-tree multiplier.
module wtm_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // pp[i][j] = a[j] & b[i], with weight i+j
    logic [3:0] pp [4];
    logic [1:0] s1_w1, s1_w2, s1_w3, s1_w4, s1_w5;
    logic [1:0] s2_w2, s2_w3, s2_w4, s2_w5, s2_w6;
    logic [7:0] sum_row;
    logic [7:0] carry_row;

    // Adder cells return {carry, sum}
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pp
            assign pp[gi] = a & {4{b[gi]}};
        end
    endgenerate

    // Stage 1: column heights 1,2,3,4,3,2,1 are reduced to three rows
    assign s1_w1 = ha(pp[0][1], pp[1][0]);
    assign s1_w2 = fa(pp[0][2], pp[1][1], pp[2][0]);
    assign s1_w3 = fa(pp[0][3], pp[1][2], pp[2][1]);
    assign s1_w4 = fa(pp[1][3], pp[2][2], pp[3][1]);
    assign s1_w5 = ha(pp[2][3], pp[3][2]);

    // Stage 2: the three rows are reduced to two rows; pp[3][0] joins here
    assign s2_w2 = ha(s1_w2[0], s1_w1[1]);
    assign s2_w3 = fa(s1_w3[0], s1_w2[1], pp[3][0]);
    assign s2_w4 = ha(s1_w4[0], s1_w3[1]);
    assign s2_w5 = ha(s1_w5[0], s1_w4[1]);
    assign s2_w6 = ha(pp[3][3], s1_w5[1]);

    // Final carry-propagate add of the sum row and the carry row
    assign sum_row   = {1'b0, s2_w6[0], s2_w5[0], s2_w4[0], s2_w3[0], s2_w2[0], s1_w1[0], pp[0][0]};
    assign carry_row = {s2_w6[1], s2_w5[1], s2_w4[1], s2_w3[1], s2_w2[1], 3'b000};
    assign p         = sum_row + carry_row;
endmodule

module wtm4_share_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_p
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [IDW:0]   NREQ_W    = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

    state_t         state_reg, state_next;
    logic [IDW-1:0] last_grant_reg;
    logic [IDW-1:0] id_reg;
    logic [3:0]     a_reg, b_reg;
    logic           rsp_valid_reg;
    logic [IDW-1:0] rsp_id_reg;
    logic [7:0]     rsp_p_reg;

    logic [3:0]     a_arr [NREQ];
    logic [3:0]     b_arr [NREQ];
    logic [7:0]     core_p;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic           accept;
    logic           rsp_clear;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_port
            assign a_arr[gi]     = req_a[4*gi +: 4];
            assign b_arr[gi]     = req_b[4*gi +: 4];
            // Only the granted bit is raised, and only when the FSM may accept
            assign req_ready[gi] = accept && (grant_idx == IDW'(gi));
        end
    endgenerate

    wtm_4bit u_core (
        .a (a_reg),
        .b (b_reg),
        .p (core_p)
    );

    // Round-robin pick: the first valid index after last_grant, wrapping around
    always_comb begin
        logic [IDW:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant_reg} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_any && req_valid[cand[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    // Next-state logic and the accept/clear strobes
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        rsp_clear  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = RESP;
            end
            RESP: begin
                // rsp_valid is always high in RESP, so rsp_ready alone completes the handshake
                if (rsp_ready) begin
                    rsp_clear  = 1'b1;
                    state_next = IDLE;
`ifdef WTM_ARB_BACK2BACK_EN
                    if (grant_any) begin
                        accept     = 1'b1;
                        state_next = CALC;
                    end
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture on accept; product capture in CALC; release on the response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= LAST_INIT;
            id_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_p_reg      <= '0;
        end else begin
            if (accept) begin
                a_reg          <= a_arr[grant_idx];
                b_reg          <= b_arr[grant_idx];
                id_reg         <= grant_idx;
                last_grant_reg <= grant_idx;
            end
            if (state_reg == CALC) begin
                rsp_p_reg     <= core_p;
                rsp_id_reg    <= id_reg;
                rsp_valid_reg <= 1'b1;
            end else if (rsp_clear) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_p     = rsp_p_reg;
endmodule

// File: tb/tb_wtm4_share_arbiter.sv
// Testbench for wtm4_share_arbiter. This bench uses a transaction-level reference
// model built from the arbitration rules and plain a*b arithmetic. It applies
// directed steps plus a randomized phase, and prints one line per response.
`timescale 1ns/1ps
module tb_wtm4_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);
`ifdef WTM_ARB_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_p;

    always #5 clk = ~clk;

    wtm4_share_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    int total = 0;
    int bad   = 0;

    // Requester-side stimulus state.
    // mode 0: drop valid once accepted.
    // mode 1: hold valid and operands.
    // mode 2: random.
    logic [NREQ-1:0] v;
    logic [3:0]      a [NREQ];
    logic [3:0]      b [NREQ];
    int              mode;

    // Reference model: the job being multiplied, and the response being offered
    int m_last;
    bit m_calc;
    bit m_rsp_valid;
    int m_a, m_b, m_gid, m_id, m_p;

    // Observations taken from the DUT pins
    int cyc = 0;
    int n_rsp = 0;
    int og_q[$];
    int og_cyc_q[$];
    int orsp_id_q[$];
    int orsp_p_q[$];
    int orsp_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]     = v[i];
            req_a[4*i +: 4]  = a[i];
            req_b[4*i +: 4]  = b[i];
        end
    endtask

    function automatic int ohidx(input logic [NREQ-1:0] x);
        for (int i = 0; i < NREQ; i++) begin
            if (x[i]) return i;
        end
        return -1;
    endfunction

    // One clock cycle: check at negedge, then advance the model across the edge
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        int  g;
        int  idx;
        bit  can_grant;
        bit  hs;
        @(negedge clk);
        exp_ready = '0;
        g = -1;
        can_grant = !m_calc && (!m_rsp_valid || (B2B && rsp_ready));
        if (can_grant) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        chk("rsp_id", 32'(rsp_id), m_id);
        chk("rsp_p", 32'(rsp_p), m_p);
        if (req_ready != '0) begin
            og_q.push_back(ohidx(req_ready));
            og_cyc_q.push_back(cyc);
        end
        if (rsp_valid && rsp_ready) begin
            orsp_id_q.push_back(int'(rsp_id));
            orsp_p_q.push_back(int'(rsp_p));
            orsp_cyc_q.push_back(cyc);
            n_rsp++;
            $display("rsp cyc=%0d id=%0d p=%0d", cyc, rsp_id, rsp_p);
        end
        hs = m_rsp_valid && rsp_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) m_rsp_valid = 1'b0;
        if (m_calc) begin
            m_rsp_valid = 1'b1;
            m_p = m_a * m_b;
            m_id = m_gid;
            m_calc = 1'b0;
        end
        if (mode == 2) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i] = 1'b1;
                    a[i] = 4'($urandom);
                    b[i] = 4'($urandom);
                end
            end
        end
        if (g >= 0) begin
            m_calc = 1'b1;
            m_a = int'(a[g]);
            m_b = int'(b[g]);
            m_gid = g;
            m_last = g;
            if (mode == 0) begin
                v[g] = 1'b0;
            end else if (mode == 2) begin
                v[g] = 1'($urandom_range(0, 1));
                a[g] = 4'($urandom);
                b[g] = 4'($urandom);
            end
        end
        drive();
    endtask

    task automatic model_reset();
        m_last = NREQ - 1;
        m_calc = 1'b0;
        m_rsp_valid = 1'b0;
        m_id = 0;
        m_p = 0;
        m_a = 0;
        m_b = 0;
        m_gid = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_p", 32'(rsp_p), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_rsp(input int target, input int budget);
        int n = 0;
        while (n_rsp < target && n < budget) begin
            cycle();
            n++;
        end
        chk("rsp_count", n_rsp, target);
    endtask

    task automatic drain();
        int n = 0;
        v = '0;
        mode = 0;
        rsp_ready = 1'b1;
        drive();
        while ((m_calc || m_rsp_valid) && n < 10) begin
            cycle();
            n++;
        end
        chk("drain_rsp_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        int r0, g0, n, cnt;
        int served [NREQ];
        v = '0;
        mode = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        drive();
        model_reset();

        // Reset state
        do_reset();
        cycle();

        // 1: single requester, 15*15; grant-to-response distance of 2 cycles
        rsp_ready = 1'b1;
        v[0] = 1'b1;
        a[0] = 4'd15;
        b[0] = 4'd15;
        drive();
        r0 = n_rsp;
        g0 = og_q.size();
        run_rsp(r0 + 1, 10);
        chk("t1_id", orsp_id_q[r0], 0);
        chk("t1_p", orsp_p_q[r0], 225);
        chk("t1_lat", orsp_cyc_q[r0] - og_cyc_q[g0], 2);
        drain();

        // 2: all valid after reset, a_i=i+1, b_i=3 -> grants 0,1,2,3,0
        do_reset();
        mode = 1;
        v = '1;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = 4'(i + 1);
            b[i] = 4'd3;
        end
        rsp_ready = 1'b1;
        drive();
        g0 = og_q.size();
        r0 = n_rsp;
        n = 0;
        while (og_q.size() < g0 + 5 && n < 30) begin
            cycle();
            n++;
        end
        chk("t2_grants", og_q.size(), g0 + 5);
        for (int k = 0; k < 5; k++) chk("t2_grant", og_q[g0 + k], k % NREQ);
        for (int k = 0; k < 4; k++) chk("t2_p", orsp_p_q[r0 + k], (k + 1) * 3);
        drain();

        // 3: response back-pressured 5 cycles; a late requester drops before being granted
        mode = 0;
        rsp_ready = 1'b0;
        v[1] = 1'b1;
        a[1] = 4'd7;
        b[1] = 4'd9;
        drive();
        n = 0;
        while (!m_rsp_valid && n < 6) begin
            cycle();
            n++;
        end
        g0 = og_q.size();
        r0 = n_rsp;
        v[3] = 1'b1;
        a[3] = 4'd2;
        b[3] = 4'd2;
        drive();
        repeat (3) cycle();
        v[3] = 1'b0;
        drive();
        repeat (2) cycle();
        chk("t3_held", n_rsp, r0);
        rsp_ready = 1'b1;
        run_rsp(r0 + 1, 5);
        chk("t3_p", orsp_p_q[r0], 63);
        chk("t3_id", orsp_id_q[r0], 1);
        repeat (3) cycle();
        chk("t3_single", n_rsp, r0 + 1);
        chk("t3_no_grant", og_q.size(), g0);

        // 4: reset while in CALC; state and outputs clear without a clock edge
        v[2] = 1'b1;
        a[2] = 4'd5;
        b[2] = 4'd6;
        drive();
        n = 0;
        while (!m_calc && n < 6) begin
            cycle();
            n++;
        end
        v = '1;
        drive();
        rst = 1'b1;
        #1;
        chk("t4_rsp_valid", 32'(rsp_valid), 0);
        chk("t4_ready_idle", 32'(req_ready), 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        r0 = n_rsp;
        cycle();
        chk("t4_first_grant", og_q[og_q.size() - 1], 0);
        drain();
        chk("t4_one_rsp", n_rsp, r0 + 1);

        // 5: every (a,b) pair on requester 2
        mode = 0;
        rsp_ready = 1'b1;
        for (int x = 0; x < 256; x++) begin
            v[2] = 1'b1;
            a[2] = 4'(x);
            b[2] = 4'(x >> 4);
            drive();
            r0 = n_rsp;
            run_rsp(r0 + 1, 8);
            chk("t5_p", orsp_p_q[r0], (x % 16) * (x / 16));
            chk("t5_id", orsp_id_q[r0], 2);
        end
        drain();

        // 6: two continuous requesters; check the response period and alternating ids
        do_reset();
        mode = 1;
        v = 4'b0011;
        a[0] = 4'd2;
        b[0] = 4'd3;
        a[1] = 4'd4;
        b[1] = 4'd5;
        rsp_ready = 1'b1;
        drive();
        r0 = n_rsp;
        run_rsp(r0 + 6, 40);
        for (int k = 0; k < 6; k++) chk("t6_id", orsp_id_q[r0 + k], k % 2);
        for (int k = 1; k < 6; k++) chk("t6_gap", orsp_cyc_q[r0 + k] - orsp_cyc_q[r0 + k - 1], B2B ? 2 : 3);
        drain();

        // Randomized traffic with random back-pressure
        do_reset();
        mode = 2;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'($urandom_range(0, 1));
            a[i] = 4'($urandom);
            b[i] = 4'($urandom);
        end
        drive();
        repeat (1500) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        // Fairness: all valid from an arbitrary last grant; each id twice in 2*NREQ grants
        mode = 1;
        v = '1;
        rsp_ready = 1'b1;
        drive();
        g0 = og_q.size();
        n = 0;
        while (og_q.size() < g0 + 2 * NREQ && n < 40) begin
            cycle();
            n++;
        end
        chk("fair_grants", og_q.size(), g0 + 2 * NREQ);
        for (int i = 0; i < NREQ; i++) served[i] = 0;
        for (int k = 0; k < 2 * NREQ; k++) begin
            cnt = og_q[g0 + k];
            if (cnt >= 0 && cnt < NREQ) served[cnt]++;
        end
        for (int i = 0; i < NREQ; i++) chk("fair_count", served[i], 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
